// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared ALU opcode width, opcode enum and arbiter state encoding
package alu_arb_pkg;
   localparam int ALU_OP_W = 4;
   typedef enum logic [ALU_OP_W-1:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR,
      ALU_XOR, ALU_SLL, ALU_SLA, ALU_SRL, ALU_SRA
   } alu_op_e;
   typedef enum logic {ARB, LOCKED} arb_state_e;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: circular first-one finder starting at ptr; returns onehot grant, its index and any
module rr_pick #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [N-1:0]         grant,
   output logic [$clog2(N)-1:0] idx,
   output logic                 any
);
   localparam int IW = $clog2(N);
   logic [IW-1:0] j;
   assign any = |req;
   // Walk offsets from farthest to nearest so the closest request at/after ptr wins
   always_comb begin
      idx = '0;
      j = '0;
      for (int k = N - 1; k >= 0; k--) begin
         j = IW'((int'(ptr) + k) % N);
         if (req[j]) idx = j;
      end
      grant = '0;
      grant[idx] = any;
   end
endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin/lockable share of one ALU with a 1-entry response buffer.
// Define ALU_ARB_STATS_EN to build the per-requester saturating grant counters.
module alu_share_arbiter
   import alu_arb_pkg::*;
#(
   parameter int NREQ         = 4,
   parameter int DATA_W       = 32,
   parameter int LOCK_TIMEOUT = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NREQ-1:0]           req_valid,
   output logic [NREQ-1:0]           req_ready,
   input  logic [NREQ-1:0]           req_lock,
   input  logic [NREQ*ALU_OP_W-1:0]  req_op,
   input  logic [NREQ*DATA_W-1:0]    req_a,
   input  logic [NREQ*DATA_W-1:0]    req_b,
   output logic [DATA_W-1:0]         alu_val1,
   output logic [DATA_W-1:0]         alu_val2,
   output logic [ALU_OP_W-1:0]       alu_cmd,
   input  logic [DATA_W-1:0]         alu_out,
   input  logic                      alu_zero,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [$clog2(NREQ)-1:0]   rsp_id,
   output logic [DATA_W-1:0]         rsp_data,
   output logic                      rsp_zero,
   output logic [NREQ*16-1:0]        stat_grants
);
   localparam int IW = $clog2(NREQ);
   localparam int CW = $clog2(LOCK_TIMEOUT + 1);
   arb_state_e state, state_n;
   logic [IW-1:0] ptr, ptr_n, owner, owner_n, idx;
   logic [CW-1:0] idle, idle_n;
   logic [NREQ-1:0] elig, grant;
   logic any, can_issue, xfer;

   function automatic logic [IW-1:0] inc(input logic [IW-1:0] i);
      return (i == IW'(NREQ - 1)) ? '0 : i + 1'b1;
   endfunction

   assign can_issue = !rsp_valid || rsp_ready;
   assign elig = (state == LOCKED) ? req_valid & (NREQ'(1) << owner) : req_valid;
   assign req_ready = can_issue ? grant : '0;
   assign xfer = any && can_issue;

   rr_pick #(.N(NREQ)) u_pick (.req(elig), .ptr(ptr), .grant(grant), .idx(idx), .any(any));

   always_comb begin
      alu_val1 = '0;
      alu_val2 = '0;
      alu_cmd = '0;
      for (int i = 0; i < NREQ; i++)
         if (xfer && idx == IW'(i)) begin
            alu_val1 = req_a[i*DATA_W +: DATA_W];
            alu_val2 = req_b[i*DATA_W +: DATA_W];
            alu_cmd = req_op[i*ALU_OP_W +: ALU_OP_W];
         end
   end

   // Idle only counts cycles the owner could have issued but had nothing valid
   always_comb begin
      state_n = state;
      ptr_n = ptr;
      owner_n = owner;
      idle_n = idle;
      if (state == ARB) begin
         if (xfer) begin
            ptr_n = inc(idx);
            if (req_lock[idx]) begin
               state_n = LOCKED;
               owner_n = idx;
               idle_n = '0;
            end
         end
      end else if (xfer) begin
         idle_n = '0;
         if (!req_lock[owner]) begin
            state_n = ARB;
            ptr_n = inc(owner);
         end
      end else if (req_valid[owner]) begin
         idle_n = '0;
      end else if (can_issue) begin
         idle_n = idle + 1'b1;
         if (idle_n == CW'(LOCK_TIMEOUT)) begin
            state_n = ARB;
            ptr_n = inc(owner);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ARB;
         ptr <= '0;
         owner <= '0;
         idle <= '0;
         rsp_valid <= 1'b0;
         rsp_id <= '0;
         rsp_data <= '0;
         rsp_zero <= 1'b0;
      end else begin
         state <= state_n;
         ptr <= ptr_n;
         owner <= owner_n;
         idle <= idle_n;
         if (xfer) begin
            rsp_valid <= 1'b1;
            rsp_id <= idx;
            rsp_data <= alu_out;
            rsp_zero <= alu_zero;
         end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
         end
      end
   end

`ifdef ALU_ARB_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_grants <= '0;
      end else begin
         for (int i = 0; i < NREQ; i++)
            if (xfer && idx == IW'(i) && stat_grants[i*16 +: 16] != 16'hFFFF)
               stat_grants[i*16 +: 16] <= stat_grants[i*16 +: 16] + 16'd1;
      end
   end
`else
   assign stat_grants = '0;
`endif
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed tests with literal expectations plus a per-cycle reference model
module tb_alu_share_arbiter;
   import alu_arb_pkg::*;
   logic clk = 1'b0, rst_n = 1'b0, rsp_ready = 1'b1;
   logic [3:0] v = '0, lk = '0, req_ready;
   logic [3:0] op [4];
   logic [31:0] a [4], b [4];
   logic [15:0] req_op;
   logic [127:0] req_a, req_b;
   logic [31:0] alu_val1, alu_val2, alu_out, rsp_data;
   logic [3:0] alu_cmd;
   logic alu_zero, rsp_valid, rsp_zero;
   logic [1:0] rsp_id;
   logic [63:0] stat_grants;
   int errors = 0, checks = 0;

   always #5 clk = ~clk;

   alu_share_arbiter #(.NREQ(4), .DATA_W(32), .LOCK_TIMEOUT(8)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(v), .req_ready(req_ready), .req_lock(lk),
      .req_op(req_op), .req_a(req_a), .req_b(req_b), .alu_val1(alu_val1), .alu_val2(alu_val2),
      .alu_cmd(alu_cmd), .alu_out(alu_out), .alu_zero(alu_zero), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_zero(rsp_zero),
      .stat_grants(stat_grants)
   );

   function automatic logic [31:0] alu_f(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
      case (o)
         ALU_ADD: return x + y;
         ALU_SUB: return x - y;
         ALU_AND: return x & y;
         ALU_OR:  return x | y;
         ALU_NOR: return ~(x | y);
         ALU_XOR: return x ^ y;
         ALU_SLL, ALU_SLA: return x << y[4:0];
         ALU_SRL: return x >> y[4:0];
         ALU_SRA: return $unsigned($signed(x) >>> y[4:0]);
         default: return 32'd0;
      endcase
   endfunction

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         req_op[i*4 +: 4] = op[i];
         req_a[i*32 +: 32] = a[i];
         req_b[i*32 +: 32] = b[i];
      end
      alu_out = alu_f(alu_cmd, alu_val1, alu_val2);
      alu_zero = (alu_out == 32'd0);
   end

   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h @%0t", n, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: state after the most recent edge, advanced at each negedge
   int m_ptr = 0, m_owner = 0, m_idle = 0, m_id = 0, g;
   bit m_lock = 0, m_v = 0, m_zero = 0, can;
   logic [31:0] m_data = '0;
   int m_cnt [4] = '{0, 0, 0, 0};
   logic [63:0] m_stats;

   always @(negedge clk) begin
      if (!rst_n) begin
         m_ptr = 0; m_owner = 0; m_idle = 0; m_id = 0; m_lock = 0; m_v = 0; m_zero = 0; m_data = '0;
         m_cnt = '{0, 0, 0, 0};
         chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
         chk("rst_rsp_data", 64'(rsp_data), 64'd0);
         chk("rst_stats", stat_grants, 64'd0);
      end else begin
         g = -1;
         can = !m_v || rsp_ready;
         if (can) begin
            if (m_lock) begin
               if (v[m_owner]) g = m_owner;
            end else begin
               for (int k = 3; k >= 0; k--) if (v[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
            end
         end
         m_stats = '0;
`ifdef ALU_ARB_STATS_EN
         for (int i = 0; i < 4; i++) m_stats[i*16 +: 16] = 16'(m_cnt[i]);
`endif
         chk("m_ready", 64'(req_ready), (g < 0) ? 64'd0 : 64'(1) << g);
         chk("m_val1", 64'(alu_val1), (g < 0) ? 64'd0 : 64'(a[g]));
         chk("m_val2", 64'(alu_val2), (g < 0) ? 64'd0 : 64'(b[g]));
         chk("m_cmd", 64'(alu_cmd), (g < 0) ? 64'd0 : 64'(op[g]));
         chk("m_rsp_valid", 64'(rsp_valid), 64'(m_v));
         if (m_v) begin
            chk("m_rsp_id", 64'(rsp_id), 64'(m_id));
            chk("m_rsp_data", 64'(rsp_data), 64'(m_data));
            chk("m_rsp_zero", 64'(rsp_zero), 64'(m_zero));
         end
         chk("m_stats", stat_grants, m_stats);
         if (g >= 0) begin
            m_v = 1; m_id = g; m_data = alu_f(op[g], a[g], b[g]); m_zero = (m_data == 0);
            if (m_cnt[g] < 65535) m_cnt[g]++;
            if (m_lock) begin
               m_idle = 0;
               if (!lk[g]) begin m_lock = 0; m_ptr = (m_owner + 1) % 4; end
            end else begin
               m_ptr = (g + 1) % 4;
               if (lk[g]) begin m_lock = 1; m_owner = g; m_idle = 0; end
            end
         end else begin
            if (rsp_ready) m_v = 0;
            if (m_lock) begin
               if (v[m_owner]) m_idle = 0;
               else if (can) begin
                  m_idle++;
                  if (m_idle == 8) begin m_lock = 0; m_ptr = (m_owner + 1) % 4; end
               end
            end
         end
      end
   end

   logic [1:0] t2_id [6] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
   logic [31:0] t2_d [6] = '{32'd42, 32'd6, 32'hF8000000, 32'd101, 32'd42, 32'd6};

   initial begin
      op = '{ALU_ADD, ALU_SUB, ALU_XOR, ALU_SRA};
      a = '{32'd100, 32'd50, 32'd12, 32'h80000000};
      b = '{32'd1, 32'd8, 32'd10, 32'd4};
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("t1_reset_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("t1_reset_rsp_id", 64'(rsp_id), 64'd0);
      // 1: single ADD
      op[0] = ALU_ADD; a[0] = 32'd5; b[0] = 32'd7; v = 4'b0001;
      #1;
      chk("t1_ready", 64'(req_ready), 64'h1);
      chk("t1_val1", 64'(alu_val1), 64'd5);
      step();
      v = 4'b0000;
      chk("t1_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("t1_rsp_id", 64'(rsp_id), 64'd0);
      chk("t1_rsp_data", 64'(rsp_data), 64'd12);
      chk("t1_rsp_zero", 64'(rsp_zero), 64'd0);
      step();
      chk("t1_drained", 64'(rsp_valid), 64'd0);
      // 2: all valid, round robin from ptr=1
      a[0] = 32'd100; b[0] = 32'd1; v = 4'b1111;
      for (int k = 0; k < 6; k++) begin
         #1;
         chk("t2_ready", 64'(req_ready), 64'(1) << t2_id[k]);
         @(posedge clk); #1;
         chk("t2_rsp_id", 64'(rsp_id), 64'(t2_id[k]));
         chk("t2_rsp_data", 64'(rsp_data), 64'(t2_d[k]));
      end
      // 3: backpressure holds the buffer, then same-cycle refill
      rsp_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("t3_ready_blocked", 64'(req_ready), 64'd0);
         step();
         chk("t3_hold_valid", 64'(rsp_valid), 64'd1);
         chk("t3_hold_data", 64'(rsp_data), 64'd6);
      end
      rsp_ready = 1'b1;
      #1;
      chk("t3_refill_ready", 64'(req_ready), 64'h8);
      step();
      v = 4'b0000;
      chk("t3_refill_valid", 64'(rsp_valid), 64'd1);
      chk("t3_refill_id", 64'(rsp_id), 64'd3);
      chk("t3_refill_data", 64'(rsp_data), 64'hF8000000);
      step();
      // 4: req1 locks for a sequence while req0/2 wait
      op[1] = ALU_SUB; a[1] = 32'd9; b[1] = 32'd9; lk = 4'b0010; v = 4'b0010;
      #1;
      chk("t4_first_ready", 64'(req_ready), 64'h2);
      step();
      chk("t4_zero", 64'(rsp_zero), 64'd1);
      v = 4'b0111; op[1] = ALU_ADD; a[1] = 32'd1; b[1] = 32'd2;
      #1;
      chk("t4_locked_ready", 64'(req_ready), 64'h2);
      step();
      chk("t4_data1", 64'(rsp_data), 64'd3);
      a[1] = 32'd3;
      step();
      a[1] = 32'd4; lk = 4'b0000;
      #1;
      chk("t4_last_ready", 64'(req_ready), 64'h2);
      step();
      chk("t4_last_data", 64'(rsp_data), 64'd6);
      #1;
      chk("t4_release_ready", 64'(req_ready), 64'h4);
      step();
      chk("t4_release_id", 64'(rsp_id), 64'd2);
      v = 4'b0000;
      step();
      // 5: lock timeout after 8 idle owner cycles
      v = 4'b0100; lk = 4'b0100;
      step();
      v = 4'b0001; lk = 4'b0000;
      for (int k = 0; k < 8; k++) begin
         #1;
         chk("t5_idle_ready", 64'(req_ready), 64'd0);
         step();
      end
      #1;
      chk("t5_after_timeout", 64'(req_ready), 64'h1);
      step();
      chk("t5_id", 64'(rsp_id), 64'd0);
      // 6: async reset while locked with a buffered response
      v = 4'b0010; lk = 4'b0010;
      step();
      rsp_ready = 1'b0; v = 4'b0000; lk = 4'b0000;
      chk("t6_pre_valid", 64'(rsp_valid), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", 64'(rsp_valid), 64'd0);
      chk("t6_rst_id", 64'(rsp_id), 64'd0);
      chk("t6_rst_data", 64'(rsp_data), 64'd0);
      chk("t6_rst_stats", stat_grants, 64'd0);
      step();
      v = 4'b0011; rsp_ready = 1'b1; rst_n = 1'b1;
      #1;
      chk("t6_first_ready", 64'(req_ready), 64'h1);
      step();
      chk("t6_first_id", 64'(rsp_id), 64'd0);
      v = 4'b0000;
      repeat (3) step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
